// File: rtl/multi_iter_if.sv
// Handshake bundle for the multi_iter iterative multiplier.
// Carries the operand side (A, B, is_signed, i_valid, ready) and the
// product side (P, o_valid, o_ready). WIDTH must match the multiplier
// instance that uses it as a port.
//   master : producer of operands and consumer of products (agent / sink)
//   slave  : the multiplier itself
interface multi_iter_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               is_signed;
  logic               i_valid;
  logic               ready;
  logic [2*WIDTH-1:0] P;
  logic               o_valid;
  logic               o_ready;

  modport master (
    output A, B, is_signed, i_valid, o_ready,
    input  ready, P, o_valid
  );

  modport slave (
    input  A, B, is_signed, i_valid, o_ready,
    output ready, P, o_valid
  );

endinterface : multi_iter_if

// File: rtl/multi_iter.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Operands are accepted in IDLE, reduced to magnitudes, and STEP bits of the
// multiplier magnitude are retired per BUSY cycle. After N = WIDTH/STEP cycles
// the sign-corrected product is registered and held in DONE until the
// downstream side takes it.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of multi_iter_if:
//            A, B, is_signed, i_valid  -> operands (is_signed sampled at accept)
//            ready                     <- operand handshake
//            P, o_valid                <- product and its valid
//            o_ready                   -> product handshake
module multi_iter #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  multi_iter_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if ((STEP < 1) || (STEP > WIDTH) || ((WIDTH % STEP) != 0)) begin : g_bad_step
      $error("multi_iter: STEP must be in 1..WIDTH and divide WIDTH");
    end
    if ($bits(bus.A) != WIDTH) begin : g_bad_if_width
      $error("multi_iter: interface WIDTH differs from module WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude in W+1 bits so that -2^(W-1) becomes +2^(W-1) without overflow.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v,
                                               input logic             sgn);
    logic [WIDTH:0] ext;
    ext = {sgn & v[WIDTH-1], v};
    if (ext[WIDTH]) begin
      return (~ext) + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      return ext;
    end
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic               finish_s;
  logic               release_s;

  logic [PW-1:0]      mcand_r;   // |A|, pre-shifted by STEP each BUSY cycle
  logic [WIDTH:0]     mplier_r;  // |B|, consumed STEP LSBs at a time
  logic               neg_r;
  logic [PW-1:0]      acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [PW-1:0]      p_r;
  logic               o_valid_r;
  logic               ready_r;

  logic [PW-1:0]      pp_s;
  logic [PW-1:0]      sum_s;
  logic [PW-1:0]      result_s;

  // Partial product of this cycle, running sum and final sign correction.
  // Shifting the multiplicand each cycle is the same as shifting the partial
  // product by cnt*STEP.
  always_comb begin
    pp_s  = mcand_r * {{(PW-STEP){1'b0}}, mplier_r[STEP-1:0]};
    sum_s = acc_r + pp_s;
    if (neg_r) begin
      result_s = (~sum_s) + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      result_s = sum_s;
    end
  end

  // Next-state logic and per-edge control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_valid && ready_r) begin
          accept_s     = 1'b1;
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_LAST) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        // o_valid is always high in DONE, so o_ready alone completes the handshake.
        if (bus.o_ready) begin
          release_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture and shift-add iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {(WIDTH+1){1'b0}};
      neg_r    <= 1'b0;
      acc_r    <= {PW{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      mcand_r  <= {{(WIDTH-1){1'b0}}, magnitude(bus.A, bus.is_signed)};
      mplier_r <= magnitude(bus.B, bus.is_signed);
      neg_r    <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      acc_r    <= {PW{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == BUSY) begin
      mcand_r  <= mcand_r << STEP;
      mplier_r <= mplier_r >> STEP;
      acc_r    <= sum_s;
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  // Registered outputs: product, its valid, and operand ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= {PW{1'b0}};
      o_valid_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      if (finish_s) begin
        p_r <= result_s;
      end
      if (finish_s) begin
        o_valid_r <= 1'b1;
      end else if (release_s) begin
        o_valid_r <= 1'b0;
      end
      ready_r <= (state_next_s == IDLE);
    end
  end

  assign bus.ready   = ready_r;
  assign bus.P       = p_r;
  assign bus.o_valid = o_valid_r;

endmodule : multi_iter
